// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Brief    : Sequencing controller for the shared multiply/divide unit.
//            Detects MULT/DIV in DX, latches the destination, fires a
//            one-cycle start pulse, waits for the unit with a timeout and
//            arbitrates the result (or a status code) onto the shared
//            register-file writeback port. Stalls DX while busy.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
   parameter int MAX_CYCLES    = 40,
   parameter int MULT_EXC_CODE = 4,
   parameter int DIV_EXC_CODE  = 5,
   parameter int TIMEOUT_CODE  = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_ir,
   input  logic        flush,
   output logic        md_issue,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   input  logic        result_rdy,
   input  logic [31:0] result,
   input  logic        result_exc,
   output logic        stall_dx,
   output logic        busy,
   output logic        wb_req,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   input  logic        wb_gnt
);

   localparam logic [4:0] c_ALU_MULT   = 5'd6;
   localparam logic [4:0] c_ALU_DIV    = 5'd7;
   localparam logic [4:0] c_REG_STATUS = 5'd30;
   localparam logic [5:0] c_CNT_LAST   = 6'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_WB    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [5:0]  r_cnt;
   logic [4:0]  r_rd_pend;
   logic        r_op_div;
   logic        r_ctrl_mult;
   logic        r_ctrl_div;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic        w_is_md;
   logic        w_is_div;
   logic        w_hz;
   logic        w_issue;
   logic        w_cap_result;
   logic        w_cap_timeout;
   logic        w_unused;

   // Instruction bits that play no part in decode or hazard detection.
   assign w_unused = ^{dx_ir[11:7], dx_ir[1:0]};

   // Decode and conservative register hazard against the pending destination.
   always_comb begin
      w_is_md  = (dx_ir[31:27] == 5'd0) &&
                 (dx_ir[6:2] == c_ALU_MULT || dx_ir[6:2] == c_ALU_DIV);
      w_is_div = (dx_ir[6:2] == c_ALU_DIV);
      w_hz     = (r_rd_pend != 5'd0) &&
                 (dx_ir[26:22] == r_rd_pend ||
                  dx_ir[21:17] == r_rd_pend ||
                  dx_ir[16:12] == r_rd_pend);
   end

   // State register; reset drops any outstanding operation.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and the strobes that drive the datapath registers.
   always_comb begin
      w_next_state  = r_state;
      w_issue       = 1'b0;
      w_cap_result  = 1'b0;
      w_cap_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_is_md && !flush) begin
               w_issue      = 1'b1;
               w_next_state = S_START;
            end
         end
         S_START: begin
            w_next_state = S_BUSY;
         end
         S_BUSY: begin
            // A result arriving on the final allowed cycle still wins.
            if (result_rdy) begin
               w_cap_result = 1'b1;
               w_next_state = S_WB;
            end else if (r_cnt == c_CNT_LAST) begin
               w_cap_timeout = 1'b1;
               w_next_state  = S_WB;
            end
         end
         S_WB: begin
            if (wb_gnt) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Operand latch, start pulses, busy counter and writeback payload.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= 6'd0;
         r_rd_pend   <= 5'd0;
         r_op_div    <= 1'b0;
         r_ctrl_mult <= 1'b0;
         r_ctrl_div  <= 1'b0;
         r_wb_rd     <= 5'd0;
         r_wb_data   <= 32'd0;
      end else begin
         // Pulse is registered at issue so it lands in the START cycle.
         r_ctrl_mult <= w_issue && !w_is_div;
         r_ctrl_div  <= w_issue && w_is_div;
         if (w_issue) begin
            r_rd_pend <= dx_ir[26:22];
            r_op_div  <= w_is_div;
         end
         if (r_state == S_START) begin
            r_cnt <= 6'd0;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 6'd1;
         end
         if (w_cap_result) begin
            if (result_exc) begin
               r_wb_rd   <= c_REG_STATUS;
               r_wb_data <= r_op_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
            end else begin
               r_wb_rd   <= r_rd_pend;
               r_wb_data <= result;
            end
         end else if (w_cap_timeout) begin
            r_wb_rd   <= c_REG_STATUS;
            r_wb_data <= 32'(TIMEOUT_CODE);
         end
      end
   end

   assign md_issue  = w_issue;
   assign ctrl_MULT = r_ctrl_mult;
   assign ctrl_DIV  = r_ctrl_div;
   assign busy      = (r_state != S_IDLE);
   assign wb_req    = (r_state == S_WB);
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
   assign stall_dx  = busy && (w_is_md || w_hz);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Brief    : Directed, table-driven bench for multdiv_ctrl (MAX_CYCLES=8).
//            Each table row is one clock cycle: inputs plus expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] dx_ir;
   logic        flush;
   logic        md_issue;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        result_rdy;
   logic [31:0] result;
   logic        result_exc;
   logic        stall_dx;
   logic        busy;
   logic        wb_req;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_gnt;

   int total = 0;
   int bad   = 0;

   multdiv_ctrl #(
      .MAX_CYCLES   (8),
      .MULT_EXC_CODE(4),
      .DIV_EXC_CODE (5),
      .TIMEOUT_CODE (6)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .dx_ir     (dx_ir),
      .flush     (flush),
      .md_issue  (md_issue),
      .ctrl_MULT (ctrl_MULT),
      .ctrl_DIV  (ctrl_DIV),
      .result_rdy(result_rdy),
      .result    (result),
      .result_exc(result_exc),
      .stall_dx  (stall_dx),
      .busy      (busy),
      .wb_req    (wb_req),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_gnt    (wb_gnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] ir;
      logic        fl;
      logic        rdy;
      logic [31:0] res;
      logic        exc;
      logic        gnt;
      logic        e_iss;
      logic        e_m;
      logic        e_d;
      logic        e_st;
      logic        e_bz;
      logic        e_rq;
      logic [4:0]  e_rd;
      logic [31:0] e_dat;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
      return {op, rd, rs, rt, 5'd0, alu, 2'd0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] ir, input logic fl, input logic rdy,
                      input logic [31:0] res, input logic exc, input logic gnt,
                      input logic e_iss, input logic e_m, input logic e_d,
                      input logic e_st, input logic e_bz, input logic e_rq,
                      input logic [4:0] e_rd, input logic [31:0] e_dat);
      vec_t v;
      v.ir = ir; v.fl = fl; v.rdy = rdy; v.res = res; v.exc = exc; v.gnt = gnt;
      v.e_iss = e_iss; v.e_m = e_m; v.e_d = e_d; v.e_st = e_st;
      v.e_bz = e_bz; v.e_rq = e_rq; v.e_rd = e_rd; v.e_dat = e_dat;
      tbl.push_back(v);
   endtask

   // One clock cycle: drive inputs shortly after the edge, check, advance.
   task automatic cycle(input logic [31:0] ir, input logic fl, input logic rdy,
                        input logic [31:0] res, input logic exc, input logic gnt,
                        input logic e_iss, input logic e_m, input logic e_d,
                        input logic e_st, input logic e_bz, input logic e_rq,
                        input logic [4:0] e_rd, input logic [31:0] e_dat);
      dx_ir = ir; flush = fl; result_rdy = rdy; result = res;
      result_exc = exc; wb_gnt = gnt;
      #1;
      chk("md_issue", {31'd0, md_issue}, {31'd0, e_iss});
      chk("ctrl_MULT", {31'd0, ctrl_MULT}, {31'd0, e_m});
      chk("ctrl_DIV", {31'd0, ctrl_DIV}, {31'd0, e_d});
      chk("stall_dx", {31'd0, stall_dx}, {31'd0, e_st});
      chk("busy", {31'd0, busy}, {31'd0, e_bz});
      chk("wb_req", {31'd0, wb_req}, {31'd0, e_rq});
      if (e_rq) begin
         chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
         chk("wb_data", wb_data, e_dat);
      end
      @(posedge clock);
      #1;
   endtask

   logic [31:0] nop, mult3, mult5, mult7, mult0, div4, div6, add_r7, add_r8, add_t7, opc1;

   initial begin
      nop    = 32'd0;
      mult3  = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);
      mult5  = mk(5'd0, 5'd5, 5'd1, 5'd2, 5'd6);
      mult7  = mk(5'd0, 5'd7, 5'd1, 5'd2, 5'd6);
      mult0  = mk(5'd0, 5'd0, 5'd1, 5'd2, 5'd6);
      div4   = mk(5'd0, 5'd4, 5'd1, 5'd2, 5'd7);
      div6   = mk(5'd0, 5'd6, 5'd1, 5'd2, 5'd7);
      add_r7 = mk(5'd0, 5'd9, 5'd7, 5'd2, 5'd0);
      add_r8 = mk(5'd0, 5'd9, 5'd8, 5'd2, 5'd0);
      add_t7 = mk(5'd0, 5'd9, 5'd1, 5'd7, 5'd0);
      opc1   = mk(5'd1, 5'd3, 5'd1, 5'd2, 5'd6);

      reset = 1'b1; dx_ir = 32'd0; flush = 1'b0; result_rdy = 1'b0;
      result = 32'd0; result_exc = 1'b0; wb_gnt = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ctrl_MULT", {31'd0, ctrl_MULT}, 32'd0);
      chk("rst_ctrl_DIV", {31'd0, ctrl_DIV}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wb_req", {31'd0, wb_req}, 32'd0);
      chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_stall", {31'd0, stall_dx}, 32'd0);
      chk("rst_issue", {31'd0, md_issue}, 32'd0);
      reset = 1'b0;

      // MULT rd=3, result 0x2A at N+5, grant held high.
      add(mult3, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++)
         add(nop, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 1, 32'h2A, 0, 1, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd3, 32'h2A);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      // DIV exception at minimum latency, then immediate MULT exception.
      add(div4,  0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 1, 32'hDEAD, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd30, 32'd5);
      add(mult5, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 1, 32'hBEEF, 1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd30, 32'd4);
      add(nop,   0, 1, 32'h1234, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      // Hazards against rd=7, second MULT stalled, 5 ungranted WB cycles.
      add(mult7, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(add_r7, 0, 0, 32'h0, 0, 0, 0, 1, 0, 1, 1, 0, 5'd0, 32'h0);
      add(add_r7, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd0, 32'h0);
      add(add_r8, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(add_t7, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd0, 32'h0);
      add(mult3, 0, 1, 32'h77, 0, 0, 0, 0, 0, 1, 1, 0, 5'd0, 32'h0);
      add(mult3, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 1, 32'hBAD, 0, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 1, 32'hBAD, 1, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1, 1, 1, 5'd7, 32'h77);
      add(mult3, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 1, 32'h1, 0, 1, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd3, 32'h1);
      // Flush, non-zero opcode with ALU op 6, and rd=0 full sequence.
      add(mult3, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(opc1,  0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(mult0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 1, 32'h9, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      add(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 32'h9);
      add(nop,   0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);

      foreach (tbl[i])
         cycle(tbl[i].ir, tbl[i].fl, tbl[i].rdy, tbl[i].res, tbl[i].exc, tbl[i].gnt,
               tbl[i].e_iss, tbl[i].e_m, tbl[i].e_d, tbl[i].e_st, tbl[i].e_bz,
               tbl[i].e_rq, tbl[i].e_rd, tbl[i].e_dat);

      // Timeout: 8 BUSY cycles with no result, late result in WB ignored.
      cycle(div6, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      cycle(nop,  0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 1, 0, 5'd0, 32'h0);
      for (int i = 0; i < 8; i++)
         cycle(nop, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      cycle(nop,  0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 1, 1, 5'd30, 32'd6);
      cycle(nop,  0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd30, 32'd6);
      cycle(nop,  0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);

      // Result on the last allowed BUSY cycle beats the timeout.
      cycle(mult5, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      cycle(nop,   0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      for (int i = 0; i < 7; i++)
         cycle(nop, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      cycle(nop,   0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      cycle(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 1, 1, 5'd5, 32'h99);
      cycle(nop,   0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);

      // Reset in BUSY: everything cleared, later result_rdy ignored.
      cycle(mult3, 0, 0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      cycle(nop,   0, 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 5'd0, 32'h0);
      reset = 1'b1;
      cycle(nop,   0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd0, 32'h0);
      reset = 1'b0;
      chk("rst2_wb_rd", {27'd0, wb_rd}, 32'd0);
      chk("rst2_wb_data", wb_data, 32'd0);
      cycle(mult3, 1, 1, 32'h42, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      cycle(nop,   0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);
      cycle(nop,   0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
